// File: rtl/game_led_driver.sv
// Board LED driver: per-LED hit flash on request rise, then PWM-dimmed glow
// with optional global blink. Single clock domain, all outputs registered.
module game_led_driver #(
  parameter int PRESCALE    = 50,
  parameter int PWM_BITS    = 4,
  parameter int FLASH_TICKS = 16,
  parameter int BLINK_TICKS = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          led_req,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                blink_en,
  output logic [3:0]          led_out,
  output logic [3:0]          led_flash
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]     PS_LAST    = PS_W'(PRESCALE - 1);
  localparam logic [15:0]         BLINK_LAST = 16'(BLINK_TICKS - 1);
  localparam logic [7:0]          FLASH_LOAD = 8'(FLASH_TICKS);
  localparam logic [PWM_BITS-1:0] PWM_MAX    = {PWM_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_FLASH = 2'd1,
    ST_ON    = 2'd2
  } led_state_t;

  logic [PS_W-1:0]     presc_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] bright_r;
  logic [15:0]         blink_cnt_r;
  logic                phase_r;
  logic [3:0]          req_d_r;
  led_state_t          state_r [4];
  logic [7:0]          timer_r [4];

  logic       tick_s;
  logic [3:0] rise_s;
  logic       pwm_on_s;
  logic       blink_ok_s;

  assign tick_s     = (presc_r == PS_LAST);
  assign rise_s     = led_req & ~req_d_r;
  assign pwm_on_s   = (bright_r == PWM_MAX) | (pwm_cnt_r < bright_r);
  assign blink_ok_s = ~blink_en | ~phase_r;

  // Prescaler, free-running PWM counter, and duty latch at the PWM wrap point
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r   <= '0;
      pwm_cnt_r <= '0;
      bright_r  <= '0;
    end else begin
      if (tick_s) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PS_W'(1);
      end
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      if (pwm_cnt_r == PWM_MAX) begin
        bright_r <= brightness;
      end else begin
        bright_r <= bright_r;
      end
    end
  end

  // Blink half-period counter; runs whether or not blink is enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (tick_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 16'd1;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  // Per-LED state machines; a falling request beats flash expiry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_d_r <= '0;
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= ST_OFF;
        timer_r[i] <= '0;
      end
    end else begin
      req_d_r <= led_req;
      for (int i = 0; i < 4; i++) begin
        case (state_r[i])
          ST_OFF: begin
            if (rise_s[i]) begin
              state_r[i] <= ST_FLASH;
              timer_r[i] <= FLASH_LOAD;
            end
          end
          ST_FLASH: begin
            if (!led_req[i]) begin
              state_r[i] <= ST_OFF;
              timer_r[i] <= '0;
            end else if (tick_s) begin
              if (timer_r[i] == 8'd1) begin
                state_r[i] <= ST_ON;
                timer_r[i] <= '0;
              end else begin
                timer_r[i] <= timer_r[i] - 8'd1;
              end
            end
          end
          ST_ON: begin
            if (!led_req[i]) begin
              state_r[i] <= ST_OFF;
            end
          end
          default: begin
            state_r[i] <= ST_OFF;
            timer_r[i] <= '0;
          end
        endcase
      end
    end
  end

  // Output stage: flash overrides dimming and blink
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_out   <= '0;
      led_flash <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        led_flash[i] <= (state_r[i] == ST_FLASH);
        led_out[i]   <= (state_r[i] == ST_FLASH) |
                        ((state_r[i] == ST_ON) & pwm_on_s & blink_ok_s);
      end
    end
  end

endmodule
